// File: rtl/pixel_binner_2x2.sv
// ----------------------------------------------------------------------------
// pixel_binner_2x2
//
// Purpose:
//   2x2 binning of the per-pixel stream coming out of the camera capture
//   stage. Every 2x2 block of input pixels becomes one output pixel holding
//   the average of the four. Even-line horizontal pair sums are parked in an
//   internal line buffer and combined with the matching odd-line pair sums.
//   The result is a half-resolution stream with its own coordinates plus an
//   end-of-frame pulse for the frame-store writer that follows.
//
// Build option:
//   PIXEL_BINNER_ROUND_EN  defined   -> DATA_OUT = (sum + 2) >> 2 (round half up)
//                          undefined -> DATA_OUT = sum >> 2       (truncate)
//
// Ports:
//   PIXCLK       in   pixel clock, all logic on the rising edge
//   RESET_N      in   asynchronous active-low reset
//   PIXEL_VALID  in   input pixel strobe
//   DATA_IN      in   input pixel value            [DATA_BITS]
//   LINE_IN      in   input line index             [LINE_BITS]
//   COLUMN_IN    in   input column index           [COL_BITS]
//   OUT_VALID    out  binned pixel strobe
//   DATA_OUT     out  binned pixel value           [DATA_BITS]
//   OUT_LINE     out  binned line index            [LINE_BITS-1]
//   OUT_COLUMN   out  binned column index          [COL_BITS-1]
//   FRAME_DONE   out  one-cycle pulse after the last binned pixel of a frame
// ----------------------------------------------------------------------------
module pixel_binner_2x2 #(
   parameter int WIDTH     = 752,
   parameter int HEIGHT    = 480,
   parameter int COL_BITS  = 10,
   parameter int LINE_BITS = 9,
   parameter int DATA_BITS = 10
) (
   input  logic                   PIXCLK,
   input  logic                   RESET_N,
   input  logic                   PIXEL_VALID,
   input  logic [DATA_BITS-1:0]   DATA_IN,
   input  logic [LINE_BITS-1:0]   LINE_IN,
   input  logic [COL_BITS-1:0]    COLUMN_IN,
   output logic                   OUT_VALID,
   output logic [DATA_BITS-1:0]   DATA_OUT,
   output logic [LINE_BITS-2:0]   OUT_LINE,
   output logic [COL_BITS-2:0]    OUT_COLUMN,
   output logic                   FRAME_DONE
);

   localparam int HALF_W = WIDTH / 2;
   localparam int HALF_H = HEIGHT / 2;
   localparam int HSUM_W = DATA_BITS + 1;
   localparam int VSUM_W = DATA_BITS + 2;
   localparam int BUF_AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   // Odd trailing column/line is excluded so only complete blocks are binned.
   localparam logic [COL_BITS-1:0]  USED_W  = COL_BITS'(HALF_W * 2);
   localparam logic [LINE_BITS-1:0] USED_H  = LINE_BITS'(HALF_H * 2);
   localparam logic [COL_BITS-2:0]  LAST_OC = (COL_BITS-1)'(HALF_W - 1);
   localparam logic [LINE_BITS-2:0] LAST_OL = (LINE_BITS-1)'(HALF_H - 1);

   typedef enum logic {WAIT_SOF, RUN} state_t;

   state_t state, state_nxt;
   logic   frame_done_nxt;

   // Fold four pixels into one; the rounding constant cannot overflow
   // because (4*max + 2) still fits in VSUM_W bits.
   function automatic logic [DATA_BITS-1:0] bin_avg(input logic [VSUM_W-1:0] s);
`ifdef PIXEL_BINNER_ROUND_EN
      logic [VSUM_W-1:0] r;
      r = s + VSUM_W'(2);
      return r[VSUM_W-1:2];
`else
      return s[VSUM_W-1:2];
`endif
   endfunction

   logic                   sof, in_range, frame_end, accept;
   logic                   col_odd, line_odd, pair_hit, wr_en, out_fire;
   logic [COL_BITS-2:0]    col_half;
   logic [LINE_BITS-2:0]   line_half;
   logic [BUF_AW-1:0]      buf_addr;
   logic [HSUM_W-1:0]      hsum;
   logic [VSUM_W-1:0]      vsum;

   logic [DATA_BITS-1:0]   pair_data_p0;
   logic [COL_BITS-1:0]    pair_col_p0;
   logic                   pair_vld_p0;
   logic [HSUM_W-1:0]      rd_data_p0;
   logic                   even_ok_p0;
   logic [LINE_BITS-2:0]   even_tag_p0;
   logic [HSUM_W-1:0]      line_buf [HALF_W];

   // ---- input decode / horizontal and vertical sums (combinational) ----
   always_comb begin
      sof       = PIXEL_VALID && (LINE_IN == '0) && (COLUMN_IN == '0);
      in_range  = (COLUMN_IN < USED_W) && (LINE_IN < USED_H);
      frame_end = (state == RUN) && OUT_VALID &&
                  (OUT_LINE == LAST_OL) && (OUT_COLUMN == LAST_OC);
      // The cycle that retires the frame accepts only a fresh start.
      accept    = PIXEL_VALID && in_range &&
                  (sof || ((state == RUN) && !frame_end));
      col_odd   = COLUMN_IN[0];
      line_odd  = LINE_IN[0];
      col_half  = COLUMN_IN[COL_BITS-1:1];
      line_half = LINE_IN[LINE_BITS-1:1];
      buf_addr  = col_half[BUF_AW-1:0];
      pair_hit  = pair_vld_p0 && (pair_col_p0 == COLUMN_IN - COL_BITS'(1));
      hsum      = {1'b0, pair_data_p0} + {1'b0, DATA_IN};
      vsum      = {1'b0, hsum} + {1'b0, rd_data_p0};
      wr_en     = accept && col_odd && pair_hit && !line_odd;
      // Odd-line output only if the partner even line finished this frame.
      out_fire  = accept && col_odd && pair_hit && line_odd &&
                  even_ok_p0 && (even_tag_p0 == line_half);
   end

   // ---- frame FSM ----
   always_ff @(posedge PIXCLK or negedge RESET_N) begin
      if (!RESET_N) state <= WAIT_SOF;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      frame_done_nxt = 1'b0;
      case (state)
         WAIT_SOF: if (sof) state_nxt = RUN;
         RUN: begin
            if (frame_end) begin
               frame_done_nxt = 1'b1;
               state_nxt      = sof ? RUN : WAIT_SOF;
            end
         end
         default: state_nxt = WAIT_SOF;
      endcase
   end

   // ---- stage p0: pair register and even-line completion flag ----
   always_ff @(posedge PIXCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pair_data_p0 <= '0;
         pair_col_p0  <= '0;
         pair_vld_p0  <= 1'b0;
         even_ok_p0   <= 1'b0;
         even_tag_p0  <= '0;
      end else begin
         if (accept) begin
            if (!col_odd) begin
               pair_data_p0 <= DATA_IN;
               pair_col_p0  <= COLUMN_IN;
               pair_vld_p0  <= 1'b1;
            end else begin
               pair_vld_p0  <= 1'b0;
            end
         end
         // A restart forgets any half-written line pair from the old frame.
         if (sof) begin
            even_ok_p0 <= 1'b0;
         end else if (wr_en && (col_half == LAST_OC)) begin
            even_ok_p0  <= 1'b1;
            even_tag_p0 <= line_half;
         end
      end
   end

   // ---- stage p0: line buffer, read issued at the even-column pixel ----
   always_ff @(posedge PIXCLK) begin
      if (accept && !col_odd) rd_data_p0 <= line_buf[buf_addr];
      if (wr_en)              line_buf[buf_addr] <= hsum;
   end

   // ---- stage p1: registered outputs ----
   always_ff @(posedge PIXCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         OUT_VALID  <= 1'b0;
         DATA_OUT   <= '0;
         OUT_LINE   <= '0;
         OUT_COLUMN <= '0;
         FRAME_DONE <= 1'b0;
      end else begin
         OUT_VALID  <= out_fire;
         FRAME_DONE <= frame_done_nxt;
         if (out_fire) begin
            DATA_OUT   <= bin_avg(vsum);
            OUT_LINE   <= line_half;
            OUT_COLUMN <= col_half;
         end
      end
   end

endmodule

// File: doc/pixel_binner_2x2.md
Name: pixel_binner_2x2

Overview:
- Sits directly downstream of the camera capture stage and consumes its per-pixel stream: DATA_OUT, CURRENT_LINE, CURRENT_COLUMN and PIXEL_VALID.
- Performs 2x2 binning: each 2x2 block of input pixels becomes one output pixel equal to the average of the four.
- Holds the even-line horizontal pair sums in an internal line buffer.
- Emits a half-resolution stream with its own coordinates and an end-of-frame pulse, for the frame-store writer that follows.

Parameters:
- WIDTH, 752, input columns per line.
- HEIGHT, 480, input lines per frame.
- COL_BITS, 10, width of the input column index.
- LINE_BITS, 9, width of the input line index.
- DATA_BITS, 10, pixel width.

Ports:
- PIXCLK  input  1  pixel clock; all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- PIXEL_VALID  input  1  input pixel strobe from the capture stage.
- DATA_IN  input  DATA_BITS  input pixel value.
- LINE_IN  input  LINE_BITS  line index of the input pixel.
- COLUMN_IN  input  COL_BITS  column index of the input pixel.
- OUT_VALID  output  1  binned pixel strobe.
- DATA_OUT  output  DATA_BITS  binned pixel value.
- OUT_LINE  output  LINE_BITS-1  binned line index (LINE_IN>>1).
- OUT_COLUMN  output  COL_BITS-1  binned column index (COLUMN_IN>>1).
- FRAME_DONE  output  1  one-cycle pulse after the last binned pixel of a frame.

Behaviour:
- Reset: RESET_N is asynchronous and active-low. While asserted, all outputs are 0, the pair register and its flags are cleared, and the state is WAIT_SOF. Line buffer contents are don't-care.
- States:
  - WAIT_SOF to RUN: on PIXEL_VALID with LINE_IN==0 and COLUMN_IN==0.
  - RUN to WAIT_SOF: after the binned pixel at (HEIGHT/2-1, WIDTH/2-1) is emitted; FRAME_DONE pulses in that same transition cycle.
  - RUN to RUN: on a new (0,0) pixel; the partial frame is discarded without FRAME_DONE and the frame restarts.
- WAIT_SOF: pixels other than (0,0) are ignored. This handles attaching mid-frame.
- Even column: DATA_IN is stored in the pair register with the pair-valid flag set.
- Odd column:
  - If pair-valid is set and the stored column == COLUMN_IN-1, the 11-bit sum hsum = pair + DATA_IN is formed. Otherwise the pixel is dropped and pair-valid is cleared.
  - pair-valid is cleared after use.
- Even line: hsum is written to line_buf[COLUMN_IN>>1]. The buffer depth is WIDTH/2 and its entries are 11 bits.
- Odd line: hsum plus line_buf[COLUMN_IN>>1] gives a 12-bit sum; DATA_OUT = sum>>2 (see the optional feature).
  - The buffer read is synchronous, issued with address COLUMN_IN>>1 at the even-column pixel.
  - Odd-line output is produced only if the corresponding even line (LINE_IN-1) was written this frame. A per-line-pair flag is set on completion of the even line's writes.
- Latency: OUT_VALID, DATA_OUT, OUT_LINE and OUT_COLUMN register exactly 1 PIXCLK after the odd-line, odd-column input pixel. OUT_VALID is high for one cycle per binned pixel.
- Odd dimensions: with odd WIDTH the last column is dropped; with odd HEIGHT the last line is dropped. No partial blocks are ever output.
- Gaps: PIXEL_VALID low between pixels or lines, of any length, is tolerated; state is held.
- Width rules:
  - The 12-bit sum needs no saturation: maximum (4*1023+2)>>2 = 1023.
  - Output coordinates are truncated shifts of the input coordinates.
- Reset mid-frame: outputs drop to 0 immediately and the block resumes at the next (0,0).

Optional Feature:
- Macro PIXEL_BINNER_ROUND_EN.
- Defined: DATA_OUT = (sum+2)>>2, i.e. round half up.
- Undefined: DATA_OUT = sum>>2, i.e. truncate, and the adder for the rounding constant is absent.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- WIDTH=4, HEIGHT=2. Line0 = 10,20,30,40; line1 = 30,40,50,62. Expect out(0,0)=25 and out(0,1)=46 with ROUND_EN (45 without), each one cycle after the pixel, then one FRAME_DONE pulse.
- Start with a mid-frame stream (LINE_IN=1, COLUMN_IN=2 onward), then a full frame from (0,0). Expect no OUT_VALID before (0,0), and exactly WIDTH/2*HEIGHT/2 outputs afterwards.
- All pixels = 1023. Expect DATA_OUT=1023 for every output in both builds; no overflow.
- WIDTH=5, HEIGHT=3, full frame. Expect 2x1 outputs only: column 4 and line 2 are produced nothing, and FRAME_DONE follows out(0,1).
- Assert RESET_N low during line1 of the frame, then release. Expect all outputs 0 asynchronously and no OUT_VALID until a fresh (0,0) frame, which bins correctly.
- Skip column 2 on line 1 (column 3 arrives unpaired). Expect the out(0,1) pixel to be dropped, out(0,0) normal, and no FRAME_DONE for that frame.
